// File: rtl/sap1_controller_if.sv
// Bus-side signal bundle between the SAP-1 instruction register and the controller-sequencer.
// The master side supplies the opcode; the slave (controller) drives CON, T and HLT.
interface sap1_controller_if;
    logic [4:1]  OPCODE;
    logic [12:1] CON;
    logic [6:1]  T;
    logic        HLT;

    modport master (output OPCODE, input CON, input T, input HLT);
    modport slave  (input OPCODE, output CON, output T, output HLT);
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter plus a T-state/opcode decoder
// that produces the 12-bit control word CON (Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar).
//
// state | meaning
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM onto bus, load IR
// T4    | execute 1 (also where HLT is detected and the ring freezes)
// T5    | execute 2
// T6    | execute 3
module sap1_controller #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic              CLK,
    input  logic              CLR,
    sap1_controller_if.slave  bus
);

    typedef enum logic [5:0] {
        ST_T1 = 6'b000001,
        ST_T2 = 6'b000010,
        ST_T3 = 6'b000100,
        ST_T4 = 6'b001000,
        ST_T5 = 6'b010000,
        ST_T6 = 6'b100000
    } state_e;

    localparam logic [12:1] CON_IDLE    = 12'h3E3;
    localparam logic [12:1] CON_FETCH1  = 12'h5E3;
    localparam logic [12:1] CON_FETCH2  = 12'hBE3;
    localparam logic [12:1] CON_FETCH3  = 12'h263;
    localparam logic [12:1] CON_IR_MAR  = 12'h1A3;
    localparam logic [12:1] CON_RAM_A   = 12'h2C3;
    localparam logic [12:1] CON_RAM_B   = 12'h2E1;
    localparam logic [12:1] CON_ALU_ADD = 12'h3C7;
    localparam logic [12:1] CON_ALU_SUB = 12'h3CF;
    localparam logic [12:1] CON_A_OUT   = 12'h3F2;

    state_e      r_state;
    logic        r_halted;
    state_e      w_next;
    logic        w_halted_next;
    logic [12:1] w_con;
    logic        w_hlt;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state  <= ST_T1;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= w_halted_next;
        end
    end

    always_comb begin
        w_next        = ST_T1;
        w_halted_next = r_halted;
        w_con         = CON_IDLE;
        w_hlt         = r_halted;

        if (r_halted) begin
            w_next = ST_T4;
        end else begin
            case (r_state)
                ST_T1: begin
                    w_next = ST_T2;
                    w_con  = CON_FETCH1;
                end
                ST_T2: begin
                    w_next = ST_T3;
                    w_con  = CON_FETCH2;
                end
                ST_T3: begin
                    w_next = ST_T4;
                    w_con  = CON_FETCH3;
                end
                ST_T4: begin
                    if (bus.OPCODE == OP_HLT) begin
                        w_next        = ST_T4;
                        w_halted_next = 1'b1;
                        w_hlt         = 1'b1;
                    end else begin
                        w_next = ST_T5;
                        if (bus.OPCODE == OP_LDA || bus.OPCODE == OP_ADD || bus.OPCODE == OP_SUB)
                            w_con = CON_IR_MAR;
                        else if (bus.OPCODE == OP_OUT)
                            w_con = CON_A_OUT;
                    end
                end
                ST_T5: begin
                    w_next = ST_T6;
                    if (bus.OPCODE == OP_LDA)
                        w_con = CON_RAM_A;
                    else if (bus.OPCODE == OP_ADD || bus.OPCODE == OP_SUB)
                        w_con = CON_RAM_B;
                end
                ST_T6: begin
                    w_next = ST_T1;
                    if (bus.OPCODE == OP_ADD)
                        w_con = CON_ALU_ADD;
                    else if (bus.OPCODE == OP_SUB)
                        w_con = CON_ALU_SUB;
                end
                // Non-one-hot (e.g. X at power-up) falls back to T1 on the next edge.
                default: begin
                    w_next = ST_T1;
                end
            endcase
        end

        if (CLR) begin
            w_con = CON_IDLE;
            w_hlt = 1'b0;
        end
    end

    assign bus.T   = r_state;
    assign bus.CON = w_con;
    assign bus.HLT = w_hlt;

endmodule
